// File: rtl/apb_pkg.sv
// Shared definitions for the APB responder: FSM state encoding, default widths
// and the saturating counter helper.
package apb_pkg;

   localparam int DEF_DBITS = 32;
   localparam int DEF_ABITS = 16;
   localparam int CNT_W     = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1
   } apb_state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// REG_NUM x DBITS register storage with one write port, one read port
// and a flattened view of every register.
module apb_reg_bank
   import apb_pkg::*;
#(
   parameter int DBITS   = DEF_DBITS,
   parameter int REG_NUM = 8,
   parameter int IDX_W   = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
   input  logic                     apb_clk,
   input  logic                     apb_rst,
   input  logic                     wr_en,
   input  logic [IDX_W-1:0]         wr_idx,
   input  logic [DBITS-1:0]         wr_data,
   input  logic [IDX_W-1:0]         rd_idx,
   output logic [DBITS-1:0]         rd_data,
   output logic [REG_NUM*DBITS-1:0] reg_out
);

   logic [DBITS-1:0] mem [REG_NUM];

   for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_reg
      always_ff @(posedge apb_clk or posedge apb_rst) begin
         if (apb_rst) begin
            mem[gi] <= '0;
         end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
            mem[gi] <= wr_data;
         end
      end
      assign reg_out[gi*DBITS +: DBITS] = mem[gi];
   end

   // Decoded mux so an index past REG_NUM (non power-of-two banks) reads zero.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < REG_NUM; k++) begin
         if (rd_idx == IDX_W'(k)) begin
            rd_data = mem[k];
         end
      end
   end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 responder over a word-indexed register bank with programmable wait
// states, PSLVERR on out-of-range index and saturating write/error counters.
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int DBITS       = DEF_DBITS,
   parameter int ABITS       = DEF_ABITS,
   parameter int REG_NUM     = 8,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                     apb_clk,
   input  logic                     apb_rst,
   input  logic                     apb_sel,
   input  logic                     apb_enable,
   input  logic                     apb_write,
   input  logic [ABITS-1:0]         apb_addr,
   input  logic [DBITS-1:0]         apb_wdata,
   output logic [DBITS-1:0]         apb_rdata,
   output logic                     apb_ready,
   output logic                     apb_slverr,
   output logic [REG_NUM*DBITS-1:0] reg_out,
   output logic [CNT_W-1:0]         wr_cnt,
   output logic [CNT_W-1:0]         err_cnt
);

   localparam int         IDX_W     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

   apb_state_t        state_reg;
   logic [ABITS-1:0]  addr_reg;
   logic              write_reg;
   logic [DBITS-1:0]  wdata_reg;
   logic [3:0]        wait_cnt_reg;
   logic [CNT_W-1:0]  wr_cnt_reg;
   logic [CNT_W-1:0]  err_cnt_reg;

   logic              idx_valid;
   logic              setup;
   logic              complete;
   logic              wr_inc;
   logic              err_inc;
   logic [DBITS-1:0]  rd_data;

   // Everything visible on the bus decodes from registered state only.
   assign idx_valid  = (addr_reg < ABITS'(REG_NUM));
   assign apb_ready  = (state_reg == ACCESS) && (wait_cnt_reg == WAIT_LAST);
   assign apb_slverr = apb_ready && !idx_valid;
   assign apb_rdata  = (apb_ready && !write_reg && idx_valid) ? rd_data : '0;

   assign setup    = apb_sel && !apb_enable;
   assign complete = apb_ready && apb_sel && apb_enable;
   assign wr_inc   = complete && write_reg && idx_valid;
   assign err_inc  = ((state_reg == IDLE) && apb_sel && apb_enable)
                   || ((state_reg == ACCESS) && (!apb_sel || setup))
                   || (complete && !idx_valid);

   assign wr_cnt  = wr_cnt_reg;
   assign err_cnt = err_cnt_reg;

   // A setup phase in either state (re)latches the transfer and restarts waits.
   always_ff @(posedge apb_clk or posedge apb_rst) begin
      if (apb_rst) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         write_reg    <= 1'b0;
         wdata_reg    <= '0;
         wait_cnt_reg <= '0;
         wr_cnt_reg   <= '0;
         err_cnt_reg  <= '0;
      end else begin
         if (setup) begin
            state_reg    <= ACCESS;
            addr_reg     <= apb_addr;
            write_reg    <= apb_write;
            wdata_reg    <= apb_wdata;
            wait_cnt_reg <= '0;
         end else if (state_reg == ACCESS) begin
            if (!apb_sel || apb_ready) begin
               state_reg <= IDLE;
            end else begin
               wait_cnt_reg <= wait_cnt_reg + 4'd1;
            end
         end
         if (wr_inc) begin
            wr_cnt_reg <= sat_inc(wr_cnt_reg);
         end
         if (err_inc) begin
            err_cnt_reg <= sat_inc(err_cnt_reg);
         end
      end
   end

   apb_reg_bank #(
      .DBITS   (DBITS),
      .REG_NUM (REG_NUM),
      .IDX_W   (IDX_W)
   ) u_bank (
      .apb_clk (apb_clk),
      .apb_rst (apb_rst),
      .wr_en   (wr_inc),
      .wr_idx  (addr_reg[IDX_W-1:0]),
      .wr_data (wdata_reg),
      .rd_idx  (addr_reg[IDX_W-1:0]),
      .rd_data (rd_data),
      .reg_out (reg_out)
   );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: one instance with no wait states, one with three,
// each checked against an array-based model of registers and counters.
module tb_apb_slave_regfile;

   localparam int DBITS   = 32;
   localparam int ABITS   = 16;
   localparam int REG_NUM = 8;
   localparam int CW      = REG_NUM * DBITS;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst    [2];
   logic                     sel    [2];
   logic                     en     [2];
   logic                     wr     [2];
   logic [ABITS-1:0]         addr   [2];
   logic [DBITS-1:0]         wdata  [2];
   logic [DBITS-1:0]         rdata  [2];
   logic                     ready  [2];
   logic                     slverr [2];
   logic [CW-1:0]            regout [2];
   logic [15:0]              wrc    [2];
   logic [15:0]              errc   [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      apb_slave_regfile #(
         .DBITS       (DBITS),
         .ABITS       (ABITS),
         .REG_NUM     (REG_NUM),
         .WAIT_CYCLES ((gi == 0) ? 0 : 3)
      ) u_dut (
         .apb_clk    (clk),
         .apb_rst    (rst[gi]),
         .apb_sel    (sel[gi]),
         .apb_enable (en[gi]),
         .apb_write  (wr[gi]),
         .apb_addr   (addr[gi]),
         .apb_wdata  (wdata[gi]),
         .apb_rdata  (rdata[gi]),
         .apb_ready  (ready[gi]),
         .apb_slverr (slverr[gi]),
         .reg_out    (regout[gi]),
         .wr_cnt     (wrc[gi]),
         .err_cnt    (errc[gi])
      );
   end

   int tests = 0;
   int fails = 0;

   logic [DBITS-1:0] mem [2][REG_NUM];
   int exp_wr  [2];
   int exp_err [2];

   function automatic int waitof(input int i);
      return (i == 0) ? 0 : 3;
   endfunction

   task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear(input int i);
      for (int k = 0; k < REG_NUM; k++) mem[i][k] = '0;
      exp_wr[i]  = 0;
      exp_err[i] = 0;
   endtask

   task automatic chk_state(input int i, input string tag);
      logic [CW-1:0] v;
      for (int k = 0; k < REG_NUM; k++) v[k*DBITS +: DBITS] = mem[i][k];
      chk($sformatf("%s_regout%0d", tag, i), regout[i], v);
      chk($sformatf("%s_wrcnt%0d", tag, i), CW'(wrc[i]), CW'(exp_wr[i]));
      chk($sformatf("%s_errcnt%0d", tag, i), CW'(errc[i]), CW'(exp_err[i]));
   endtask

   task automatic do_reset(input int i);
      rst[i] = 1'b1;
      @(posedge clk); #1;
      rst[i] = 1'b0;
      model_clear(i);
   endtask

   // One full transfer: setup, enable, wait for ready, completion edge.
   task automatic xfer(input int i, input bit w, input logic [ABITS-1:0] a, input logic [DBITS-1:0] d);
      int n;
      bit valid;
      logic [DBITS-1:0] exp_rd;
      valid  = (a < REG_NUM);
      exp_rd = (!w && valid) ? mem[i][a[2:0]] : '0;
      sel[i] = 1'b1; en[i] = 1'b0; wr[i] = w; addr[i] = a; wdata[i] = d;
      @(posedge clk); #1;
      en[i] = 1'b1;
      n = 0;
      while (ready[i] !== 1'b1 && n < 20) begin
         chk($sformatf("wait_slverr%0d", i), CW'(slverr[i]), CW'(1'b0));
         chk($sformatf("wait_rdata%0d", i), CW'(rdata[i]), CW'(0));
         @(posedge clk); #1;
         n++;
      end
      chk($sformatf("latency%0d", i), CW'(n), CW'(waitof(i)));
      chk($sformatf("slverr%0d a=%0h", i, a), CW'(slverr[i]), CW'(!valid));
      chk($sformatf("rdata%0d a=%0h", i, a), CW'(rdata[i]), CW'(exp_rd));
      @(posedge clk); #1;
      sel[i] = 1'b0; en[i] = 1'b0;
      if (valid) begin
         if (w) begin
            mem[i][a[2:0]] = d;
            exp_wr[i]++;
         end
      end else begin
         exp_err[i]++;
      end
      chk($sformatf("ready_drop%0d", i), CW'(ready[i]), CW'(1'b0));
      chk_state(i, "xfer");
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; sel[i] = 1'b0; en[i] = 1'b0; wr[i] = 1'b0;
         addr[i] = '0; wdata[i] = '0;
         model_clear(i);
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_ready", CW'(ready[i]), CW'(1'b0));
         chk("rst_slverr", CW'(slverr[i]), CW'(1'b0));
         chk("rst_rdata", CW'(rdata[i]), CW'(0));
         chk_state(i, "rst");
         rst[i] = 1'b0;
      end

      // Sequential writes 0..7 with no wait states
      for (int k = 0; k < 8; k++) xfer(0, 1'b1, ABITS'(k), DBITS'(k * 'h11));

      // Wait-state write then read back
      xfer(1, 1'b1, 16'd2, 32'hDEADBEEF);
      xfer(1, 1'b0, 16'd2, 32'h0);

      // Out-of-range indexes from a fresh reset
      do_reset(1);
      xfer(1, 1'b1, 16'd8, 32'h12345678);
      xfer(1, 1'b1, 16'hFFFF, 32'h9ABCDEF0);
      chk("oor_errcnt", CW'(errc[1]), CW'(2));

      // Enable without setup while idle
      sel[1] = 1'b1; en[1] = 1'b1; wr[1] = 1'b1; addr[1] = 16'd4; wdata[1] = 32'h44;
      @(posedge clk); #1;
      sel[1] = 1'b0; en[1] = 1'b0;
      exp_err[1]++;
      chk("nosetup_ready", CW'(ready[1]), CW'(1'b0));
      chk_state(1, "nosetup");

      // Select dropped during a wait state
      sel[1] = 1'b1; en[1] = 1'b0; wr[1] = 1'b1; addr[1] = 16'd4; wdata[1] = 32'h55;
      @(posedge clk); #1;
      en[1] = 1'b1;
      @(posedge clk); #1;
      sel[1] = 1'b0; en[1] = 1'b0;
      @(posedge clk); #1;
      exp_err[1]++;
      chk("abort_ready", CW'(ready[1]), CW'(1'b0));
      chk_state(1, "abort");
      xfer(1, 1'b0, 16'd4, 32'h0);

      // Setup repeated in ACCESS: first request replaced by the second
      sel[1] = 1'b1; en[1] = 1'b0; wr[1] = 1'b1; addr[1] = 16'd6; wdata[1] = 32'h66;
      @(posedge clk); #1;
      exp_err[1]++;
      xfer(1, 1'b1, 16'd5, 32'hA5A5A5A5);

      // Back-to-back transfers with no idle cycle
      xfer(0, 1'b1, 16'd1, 32'h99);
      xfer(0, 1'b1, 16'd1, 32'h11);
      xfer(0, 1'b0, 16'd1, 32'h0);
      chk("b2b_reg1", CW'(regout[0][1*DBITS +: DBITS]), CW'(32'h11));

      // Reset during the ACCESS cycle of a write to index 3
      sel[0] = 1'b1; en[0] = 1'b0; wr[0] = 1'b1; addr[0] = 16'd3; wdata[0] = 32'hCAFEF00D;
      @(posedge clk); #1;
      en[0] = 1'b1;
      chk("midrst_ready_before", CW'(ready[0]), CW'(1'b1));
      rst[0] = 1'b1;
      #1;
      model_clear(0);
      chk("midrst_ready", CW'(ready[0]), CW'(1'b0));
      chk("midrst_slverr", CW'(slverr[0]), CW'(1'b0));
      chk("midrst_rdata", CW'(rdata[0]), CW'(0));
      chk_state(0, "midrst");
      sel[0] = 1'b0; en[0] = 1'b0;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      chk_state(0, "postrst");
      xfer(0, 1'b1, 16'd3, 32'h33);
      xfer(0, 1'b0, 16'd3, 32'h0);

      // Random traffic on both instances
      for (int t = 0; t < 60; t++) begin
         int i;
         bit w;
         logic [ABITS-1:0] a;
         i = int'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) a = ABITS'($urandom_range(8, 65535));
         else a = ABITS'($urandom_range(0, 7));
         xfer(i, w, a, $urandom);
         if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
